vec_rf_wb_arbiter: RTL and testbench

- Shares the vector register file's single write port between NUM_REQ writeback requesters (e.g. ALU, load unit, mask unit).
- Round-robin arbitration with a valid/ready handshake per requester.
- Checks each request's register-group address legality against LMUL.
- Registers the winner into a one-stage output buffer that drives the regfile's wr_en / mask_wr_en / waddr / wdata / lmul for exactly one cycle per accepted write.

---
 rtl/vec_rf_pkg.sv | 22 ++
 rtl/vec_rf_wb_arbiter_rr.sv | 51 +++++
 rtl/vec_rf_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_vec_rf_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_rf_pkg.sv
// Shared definitions for the vector regfile writeback path.
// Register group encodings and the writeback request bundle.
package vec_rf_pkg;

  localparam int MAX_VLEN          = 4096;
  localparam int MAX_VEC_REGISTERS = 32;
  localparam int ADDR_WIDTH        = 32;
  localparam int REG_AW            = $clog2(MAX_VEC_REGISTERS);

  localparam logic [3:0] LMUL_1 = 4'd1;
  localparam logic [3:0] LMUL_2 = 4'd2;
  localparam logic [3:0] LMUL_4 = 4'd4;
  localparam logic [3:0] LMUL_8 = 4'd8;

  typedef struct packed {
    logic [REG_AW-1:0]   waddr;
    logic [MAX_VLEN-1:0] wdata;
    logic [3:0]          lmul;
    logic                mask;
  } rf_wb_req_t;

endpackage

// File: rtl/vec_rf_wb_arbiter_rr.sv
// Round-robin arbiter owning the rotating priority pointer.
// Search starts at the pointer; pointer moves past each accepted winner.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   s;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr_q} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      j = s[IW-1:0];
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = j;
      end
    end
    if (en_i && found) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      if (idx_o == IW'(NUM_REQ-1)) ptr_d = '0;
      else ptr_d = idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vec_rf_wb_arbiter.sv
// Shares the vector regfile write port among writeback requesters.
// Illegal register groups are accepted and dropped with an error pulse.
module vec_rf_wb_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int MAX_VLEN          = vec_rf_pkg::MAX_VLEN,
  parameter int MAX_VEC_REGISTERS = vec_rf_pkg::MAX_VEC_REGISTERS,
  parameter int ADDR_WIDTH        = vec_rf_pkg::ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][4:0]          req_waddr,
  input  logic [NUM_REQ-1:0][MAX_VLEN-1:0] req_wdata,
  input  logic [NUM_REQ-1:0][3:0]          req_lmul,
  input  logic [NUM_REQ-1:0]               req_mask,
  output logic [NUM_REQ-1:0]               req_err,
  input  logic                             wb_hold,
  output logic                             rf_wr_en,
  output logic                             rf_mask_wr_en,
  output logic [ADDR_WIDTH-1:0]            rf_waddr,
  output logic [MAX_VLEN-1:0]              rf_wdata,
  output logic [3:0]                       rf_lmul,
  output logic                             busy,
  output logic [7:0]                       err_count
);
  import vec_rf_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       idx;
  logic                accept, legal, w_mask;

  logic                wr_en_q, wr_en_d;
  logic                mwr_en_q, mwr_en_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [MAX_VLEN-1:0] wdata_q, wdata_d;
  logic [3:0]          lmul_q, lmul_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  function automatic logic grp_legal(logic [4:0] a, logic [3:0] l);
    logic [6:0] top;
    logic       enc_ok;
    top = {2'b0, a} + {3'b0, l};
    unique case (l)
      LMUL_1, LMUL_2, LMUL_4, LMUL_8: enc_ok = 1'b1;
      default:                        enc_ok = 1'b0;
    endcase
    return enc_ok
      && ((a[3:0] & (l - 4'd1)) == 4'd0)
      && (top <= 7'(MAX_VEC_REGISTERS));
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i (req_valid),
    .en_i  (reset && !wb_hold),
    .gnt_o (gnt),
    .idx_o (idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign w_mask    = req_mask[idx];
  assign legal     = w_mask || grp_legal(req_waddr[idx], req_lmul[idx]);

  // Output stage drains every cycle, so the strobes are single-cycle.
  always_comb begin
    wr_en_d  = 1'b0;
    mwr_en_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    lmul_d   = lmul_q;
    err_d    = '0;
    cnt_d    = cnt_q;
    if (accept) begin
      if (legal) begin
        wr_en_d  = !w_mask;
        mwr_en_d = w_mask;
        waddr_d  = w_mask ? 5'd0 : req_waddr[idx];
        lmul_d   = w_mask ? LMUL_1 : req_lmul[idx];
        wdata_d  = req_wdata[idx];
      end else begin
        err_d = gnt;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q  <= 1'b0;
      mwr_en_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      lmul_q   <= LMUL_1;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      mwr_en_q <= mwr_en_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      lmul_q   <= lmul_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_wr_en      = wr_en_q;
  assign rf_mask_wr_en = mwr_en_q;
  assign rf_waddr      = {{(ADDR_WIDTH-5){1'b0}}, waddr_q};
  assign rf_wdata      = wdata_q;
  assign rf_lmul       = lmul_q;
  assign busy          = wr_en_q | mwr_en_q;
  assign req_err       = err_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_vec_rf_wb_arbiter.sv
// Directed and random bench for the regfile writeback arbiter.
// Grants, errors and write contents are predicted and scoreboarded.
module tb_vec_rf_wb_arbiter;
  import vec_rf_pkg::*;

  localparam int N  = 3;
  localparam int VL = vec_rf_pkg::MAX_VLEN;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid, req_ready, req_mask, req_err;
  logic [N-1:0][4:0]     req_waddr;
  logic [N-1:0][VL-1:0]  req_wdata;
  logic [N-1:0][3:0]     req_lmul;
  logic                  wb_hold;
  logic                  rf_wr_en, rf_mask_wr_en, busy;
  logic [31:0]           rf_waddr;
  logic [VL-1:0]         rf_wdata;
  logic [3:0]            rf_lmul;
  logic [7:0]            err_count;

  int checks = 0;
  int failures = 0;

  rf_wb_req_t sb[$];
  rf_wb_req_t e;
  int         mptr, mptr_n, exp_cnt;
  logic [N-1:0] exp_err, nerr, last_rdy;
  logic       mon_on;

  logic [VL-1:0] mem [32];
  logic [VL-1:0] v0;
  logic [VL-1:0] mmem [32];
  logic [VL-1:0] mv0;

  always #5 clk = ~clk;

  vec_rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_lmul(req_lmul), .req_mask(req_mask),
    .req_err(req_err), .wb_hold(wb_hold),
    .rf_wr_en(rf_wr_en), .rf_mask_wr_en(rf_mask_wr_en),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_lmul(rf_lmul), .busy(busy), .err_count(err_count)
  );

  // Simple regfile: stores each write at its base register.
  always @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) mem[r] <= '0;
      v0 <= '0;
    end else begin
      if (rf_wr_en === 1'b1) mem[rf_waddr[4:0]] <= rf_wdata;
      if (rf_mask_wr_en === 1'b1) v0 <= rf_wdata;
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [VL-1:0] obs, logic [VL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs_lo=%0h exp_lo=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic bit tb_legal(int a, int l);
    if (!(l == 1 || l == 2 || l == 4 || l == 8)) return 1'b0;
    if (a % l != 0) return 1'b0;
    return (a + l) <= 32;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      chk("req_err", 64'(req_err), 64'(exp_err));
      chk("err_count", 64'(err_count), 64'(exp_cnt));
      chk("both_en", 64'(rf_wr_en & rf_mask_wr_en), 64'd0);
      if (rf_wr_en || rf_mask_wr_en) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("sb_wr_en", 64'(rf_wr_en), 64'(!e.mask));
          chk("sb_mask_en", 64'(rf_mask_wr_en), 64'(e.mask));
          chk("sb_waddr", 64'(rf_waddr), e.mask ? 64'd0 : 64'(e.waddr));
          chk("sb_lmul", 64'(rf_lmul), e.mask ? 64'd1 : 64'(e.lmul));
          chkw("sb_wdata", rf_wdata, e.wdata);
          chk("sb_busy", 64'(busy), 64'd1);
        end
      end else chk("busy_idle", 64'(busy), 64'd0);
    end
  end

  // Predict the grant at mid-cycle and queue what it should produce.
  task automatic sample();
    int w;
    @(negedge clk);
    w = -1;
    mptr_n = mptr;
    nerr = '0;
    if (reset && !wb_hold)
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
    chk("req_ready", 64'(req_ready), (w >= 0) ? (64'(1) << w) : 64'd0);
    last_rdy = req_ready;
    if (w >= 0) begin
      mptr_n = (w + 1) % N;
      if (req_mask[w] || tb_legal(int'(req_waddr[w]), int'(req_lmul[w]))) begin
        e.waddr = req_waddr[w];
        e.wdata = req_wdata[w];
        e.lmul  = req_lmul[w];
        e.mask  = req_mask[w];
        sb.push_back(e);
        if (req_mask[w]) mv0 = req_wdata[w];
        else mmem[req_waddr[w]] = req_wdata[w];
      end else nerr[w] = 1'b1;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset) begin
      mptr = 0;
      exp_err = '0;
      exp_cnt = 0;
    end else begin
      mptr = mptr_n;
      exp_err = nerr;
      if (nerr != '0 && exp_cnt < 255) exp_cnt++;
    end
    #1;
  endtask

  task automatic set_req(int i, int a, int l, logic [31:0] d, logic m);
    req_waddr[i] = 5'(a);
    req_lmul[i]  = 4'(l);
    req_wdata[i] = '0;
    req_wdata[i][31:0] = d;
    req_mask[i]  = m;
  endtask

  initial begin
    mon_on = 1'b0;
    mptr = 0;
    exp_cnt = 0;
    exp_err = '0;
    last_rdy = '0;
    mv0 = '0;
    for (int r = 0; r < 32; r++) mmem[r] = '0;
    reset = 1'b0;
    wb_hold = 1'b0;
    req_valid = 3'b111;
    set_req(0, 0, 8, 32'hA0, 1'b0);
    set_req(1, 8, 8, 32'hA1, 1'b0);
    set_req(2, 16, 8, 32'hA2, 1'b0);

    // Reset held two cycles with all requesters valid
    sample(); adv();
    sample();
    chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_mask_en", 64'(rf_mask_wr_en), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_lmul", 64'(rf_lmul), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_req_err", 64'(req_err), 64'd0);
    chkw("rst_wdata", rf_wdata, '0);
    adv();
    reset = 1'b1;
    mon_on = 1'b1;

    // Round-robin with all three valid
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("rr_grant", 64'(req_ready), 64'(1) << (i % 3));
      if (i == 0) chk("rr_lat", 64'(rf_wr_en), 64'd0);
      else chk("rr_wr_run", 64'(rf_wr_en), 64'd1);
      adv();
    end
    req_valid = '0;
    sample(); chk("rr_last_wr", 64'(rf_wr_en), 64'd1); adv();
    sample(); chk("rr_idle", 64'(rf_wr_en), 64'd0); adv();

    // Legality
    set_req(0, 6, 4, 32'hB0, 1'b0);
    req_valid = 3'b001;
    sample(); adv();
    set_req(1, 28, 8, 32'hB1, 1'b0);
    req_valid = 3'b010;
    sample();
    chk("lg0_err", 64'(req_err), 64'b001);
    chk("lg0_cnt", 64'(err_count), 64'd1);
    chk("lg0_wr", 64'(rf_wr_en), 64'd0);
    adv();
    set_req(2, 28, 4, 32'hB2, 1'b0);
    req_valid = 3'b100;
    sample();
    chk("lg1_err", 64'(req_err), 64'b010);
    chk("lg1_cnt", 64'(err_count), 64'd2);
    adv();
    req_valid = '0;
    sample();
    chk("lg2_wr", 64'(rf_wr_en), 64'd1);
    chk("lg2_waddr", 64'(rf_waddr), 64'd28);
    chk("lg2_lmul", 64'(rf_lmul), 64'd4);
    adv();

    // Mask write
    set_req(1, 12, 2, 32'hDEADBEEF, 1'b1);
    req_valid = 3'b010;
    sample(); adv();
    req_valid = '0;
    req_mask = '0;
    sample();
    chk("mk_mask_en", 64'(rf_mask_wr_en), 64'd1);
    chk("mk_wr_en", 64'(rf_wr_en), 64'd0);
    chk("mk_waddr", 64'(rf_waddr), 64'd0);
    adv();
    chk("mk_v0", 64'(v0[31:0]), 64'hDEADBEEF);

    // Hold: in-flight write still issues, pointer frozen
    set_req(2, 4, 4, 32'hC2, 1'b0);
    req_valid = 3'b100;
    sample(); chk("hd_pre", 64'(req_ready), 64'b100); adv();
    set_req(0, 0, 1, 32'hC0, 1'b0);
    set_req(1, 1, 1, 32'hC1, 1'b0);
    req_valid = 3'b011;
    wb_hold = 1'b1;
    for (int h = 0; h < 4; h++) begin
      sample();
      chk("hd_rdy", 64'(req_ready), 64'd0);
      if (h == 0) chk("hd_inflight", 64'(rf_wr_en), 64'd1);
      adv();
    end
    wb_hold = 1'b0;
    sample(); chk("hd_post0", 64'(req_ready), 64'b001); adv();
    sample(); chk("hd_post1", 64'(req_ready), 64'b010); adv();
    req_valid = '0;
    sample(); adv();

    // Random legal traffic; pending requests keep their fields
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_rdy[i])) begin
          int l;
          l = 1 << $urandom_range(0, 3);
          req_lmul[i]  = 4'(l);
          req_waddr[i] = 5'(l * $urandom_range(0, 32 / l - 1));
          for (int wd = 0; wd < VL / 32; wd++)
            req_wdata[i][wd*32 +: 32] = $urandom;
          req_mask[i]  = ($urandom_range(0, 9) == 0);
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
      wb_hold = ($urandom_range(0, 7) == 0);
      sample(); adv();
    end
    req_valid = '0;
    wb_hold = 1'b0;
    sample(); adv();
    sample(); adv();
    for (int r = 0; r < 32; r++) chkw($sformatf("rf_v%0d", r), mem[r], mmem[r]);
    chkw("rf_v0mask", v0, mv0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Error counter saturation
    for (int i = 0; i < N; i++) set_req(i, 1, 2, 32'hE0, 1'b0);
    req_valid = 3'b111;
    for (int c = 0; c < 260; c++) begin
      sample(); adv();
    end
    req_valid = '0;
    sample(); chk("sat_cnt", 64'(err_count), 64'd255); adv();
    sample(); chk("sat_hold", 64'(err_count), 64'd255); adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
